// File: rtl/rc5_core.sv
// RC5-W/R/B block cipher core with on-chip key expansion and one round per clock.
// Build option: define RC5_DECRYPT_EN to include the decrypt datapath; without it every operation encrypts.
module rc5_core #(
  parameter int W = 32,
  parameter int R = 12,
  parameter int B = 16
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic                                 key_wr,
  input  logic [((B > 1) ? $clog2(B) : 1)-1:0] key_addr,
  input  logic [7:0]                           key_byte,
  input  logic                                 key_exp,
  output logic                                 key_ready,
  input  logic                                 start,
  input  logic                                 mode,
  input  logic [W-1:0]                         a_in,
  input  logic [W-1:0]                         b_in,
  output logic [W-1:0]                         a_out,
  output logic [W-1:0]                         b_out,
  output logic                                 busy,
  output logic                                 done
);

  localparam int T    = 2 * (R + 1);
  localparam int U    = W / 8;
  localparam int C    = (B + U - 1) / U;
  localparam int NMIX = 3 * ((T > C) ? T : C);
  localparam int LW   = $clog2(W);
  localparam int TW   = $clog2(T);
  localparam int CW   = (C > 1) ? $clog2(C) : 1;

  localparam logic [63:0] P64 = (W == 16) ? 64'hB7E1 :
                                (W == 32) ? 64'hB7E1_5163 : 64'hB7E1_5162_8AED_2A6B;
  localparam logic [63:0] Q64 = (W == 16) ? 64'h9E37 :
                                (W == 32) ? 64'h9E37_79B9 : 64'h9E37_79B9_7F4A_7C15;
  localparam logic [W-1:0] P = P64[W-1:0];
  localparam logic [W-1:0] Q = Q64[W-1:0];

  typedef enum logic [2:0] {IDLE, KINIT, KMIX, LOAD, ROUND, OUT} state_t;

  state_t        state;
  logic [7:0]    key_mem [B];
  logic [W-1:0]  l_tab   [C];
  logic [W-1:0]  s_tab   [T];
  logic [W-1:0]  l_init  [C];
  logic [W-1:0]  ra, rb;
  logic [TW-1:0] si, ie, io;
  logic [CW-1:0] lj;
  logic [15:0]   cnt;
  logic [7:0]    rnd;
  logic [W-1:0]  mix_a, mix_s, mix_b, e_a, e_b;

  function automatic logic [W-1:0] rotl(input logic [W-1:0] x, input logic [LW-1:0] n);
    logic [2*W-1:0] d;
    d = {x, x} << n;
    return d[2*W-1:W];
  endfunction

  // Key bytes packed little-endian into L words; bytes past B stay zero.
  always_comb begin
    for (int k = 0; k < C; k++) l_init[k] = '0;
    for (int i = 0; i < B; i++) l_init[i / U][8 * (i % U) +: 8] = key_mem[i];
  end

  assign mix_a = rotl(s_tab[si] + ra + rb, LW'(3));
  assign mix_s = mix_a + rb;
  assign mix_b = rotl(l_tab[lj] + mix_s, mix_s[LW-1:0]);

  assign ie  = TW'({rnd, 1'b0});
  assign io  = ie | TW'(1);
  assign e_a = rotl(ra ^ rb, rb[LW-1:0]) + s_tab[ie];
  assign e_b = rotl(rb ^ e_a, e_a[LW-1:0]) + s_tab[io];

`ifdef RC5_DECRYPT_EN
  logic         dec;
  logic [W-1:0] d_a, d_b;

  function automatic logic [W-1:0] rotr(input logic [W-1:0] x, input logic [LW-1:0] n);
    logic [2*W-1:0] d;
    d = {x, x} >> n;
    return d[W-1:0];
  endfunction

  assign d_b = rotr(rb - s_tab[io], ra[LW-1:0]) ^ ra;
  assign d_a = rotr(ra - s_tab[ie], d_b[LW-1:0]) ^ d_b;
`else
  logic unused_mode;
  assign unused_mode = mode;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      key_ready <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      a_out     <= '0;
      b_out     <= '0;
      ra        <= '0;
      rb        <= '0;
      si        <= '0;
      lj        <= '0;
      cnt       <= '0;
      rnd       <= '0;
`ifdef RC5_DECRYPT_EN
      dec       <= 1'b0;
`endif
      for (int k = 0; k < B; k++) key_mem[k] <= '0;
      for (int k = 0; k < C; k++) l_tab[k] <= '0;
      for (int k = 0; k < T; k++) s_tab[k] <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (key_wr) begin
            key_mem[key_addr] <= key_byte;
            key_ready         <= 1'b0;
          end
          // Expansion takes priority over a coincident start.
          if (key_exp) begin
            for (int k = 0; k < C; k++) l_tab[k] <= l_init[k];
            ra        <= P;
            si        <= '0;
            cnt       <= 16'(T - 1);
            key_ready <= 1'b0;
            busy      <= 1'b1;
            state     <= KINIT;
          end else if (start && key_ready) begin
            ra    <= a_in;
            rb    <= b_in;
            busy  <= 1'b1;
            state <= LOAD;
`ifdef RC5_DECRYPT_EN
            dec   <= mode;
`endif
          end
        end
        KINIT: begin
          s_tab[si] <= ra;
          ra        <= ra + Q;
          si        <= si + TW'(1);
          if (cnt == 16'd0) begin
            cnt   <= 16'(NMIX - 1);
            ra    <= '0;
            rb    <= '0;
            si    <= '0;
            lj    <= '0;
            state <= KMIX;
          end else begin
            cnt <= cnt - 16'd1;
          end
        end
        KMIX: begin
          s_tab[si] <= mix_a;
          l_tab[lj] <= mix_b;
          ra        <= mix_a;
          rb        <= mix_b;
          si        <= (si == TW'(T - 1)) ? '0 : si + TW'(1);
          lj        <= (lj == CW'(C - 1)) ? '0 : lj + CW'(1);
          if (cnt == 16'd0) begin
            key_ready <= 1'b1;
            busy      <= 1'b0;
            state     <= IDLE;
          end else begin
            cnt <= cnt - 16'd1;
          end
        end
        LOAD: begin
          ra    <= ra + s_tab[0];
          rb    <= rb + s_tab[1];
          rnd   <= 8'd1;
          state <= ROUND;
`ifdef RC5_DECRYPT_EN
          if (dec) begin
            ra  <= ra;
            rb  <= rb;
            rnd <= 8'(R);
          end
`endif
        end
        ROUND: begin
          ra  <= e_a;
          rb  <= e_b;
          rnd <= rnd + 8'd1;
          if (rnd == 8'(R)) state <= OUT;
`ifdef RC5_DECRYPT_EN
          if (dec) begin
            ra    <= d_a;
            rb    <= d_b;
            rnd   <= rnd - 8'd1;
            state <= (rnd == 8'd1) ? OUT : ROUND;
          end
`endif
        end
        OUT: begin
          a_out <= ra;
          b_out <= rb;
`ifdef RC5_DECRYPT_EN
          if (dec) begin
            a_out <= ra - s_tab[0];
            b_out <= rb - s_tab[1];
          end
`endif
          done  <= 1'b1;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_rc5_core.sv
// Self-checking bench for rc5_core: three parameter sets driven against a word-level RC5 reference model.
`timescale 1ns/1ps
module tb_rc5_core;

  logic        clk = 1'b0;
  logic        rst;
  logic [2:0]  kwr, kexp, st;
  logic [4:0]  key_addr;
  logic [7:0]  key_byte;
  logic        mode;
  logic [63:0] a_in, b_in;
  logic [2:0]  kr, bz, dn;
  logic [31:0] ao0, bo0;
  logic [15:0] ao1, bo1;
  logic [63:0] ao2, bo2;

  int checks = 0;
  int errors = 0;

  logic [7:0]  kb [256];
  logic [63:0] ms [512];
  logic [63:0] ml [256];
  int pw [3] = '{32, 16, 64};
  int pr [3] = '{12, 8, 20};
  int pb [3] = '{16, 8, 24};

  always #5 clk = ~clk;

  rc5_core u0 (
    .clk(clk), .rst(rst), .key_wr(kwr[0]), .key_addr(key_addr[3:0]), .key_byte(key_byte),
    .key_exp(kexp[0]), .key_ready(kr[0]), .start(st[0]), .mode(mode),
    .a_in(a_in[31:0]), .b_in(b_in[31:0]), .a_out(ao0), .b_out(bo0), .busy(bz[0]), .done(dn[0]));

  rc5_core #(.W(16), .R(8), .B(8)) u1 (
    .clk(clk), .rst(rst), .key_wr(kwr[1]), .key_addr(key_addr[2:0]), .key_byte(key_byte),
    .key_exp(kexp[1]), .key_ready(kr[1]), .start(st[1]), .mode(mode),
    .a_in(a_in[15:0]), .b_in(b_in[15:0]), .a_out(ao1), .b_out(bo1), .busy(bz[1]), .done(dn[1]));

  rc5_core #(.W(64), .R(20), .B(24)) u2 (
    .clk(clk), .rst(rst), .key_wr(kwr[2]), .key_addr(key_addr), .key_byte(key_byte),
    .key_exp(kexp[2]), .key_ready(kr[2]), .start(st[2]), .mode(mode),
    .a_in(a_in), .b_in(b_in), .a_out(ao2), .b_out(bo2), .busy(bz[2]), .done(dn[2]));

  // ---------------- reference model ----------------
  function automatic logic [63:0] msk(input int w);
    return (w == 64) ? '1 : ((64'd1 << w) - 64'd1);
  endfunction

  function automatic logic [63:0] rl(input logic [63:0] x, input logic [63:0] n, input int w);
    int s;
    s = int'(n % 64'(w));
    if (s == 0) return x & msk(w);
    return ((x << s) | (x >> (w - s))) & msk(w);
  endfunction

  function automatic logic [63:0] rr(input logic [63:0] x, input logic [63:0] n, input int w);
    int s;
    s = int'(n % 64'(w));
    if (s == 0) return x & msk(w);
    return ((x >> s) | (x << (w - s))) & msk(w);
  endfunction

  task automatic expand_model(input int d);
    int w, r, b, u, c, t, n, i, j;
    logic [63:0] m, p, q, a, bb;
    w = pw[d]; r = pr[d]; b = pb[d];
    u = w / 8; c = (b + u - 1) / u; t = 2 * (r + 1);
    m = msk(w);
    p = (w == 16) ? 64'hB7E1 : (w == 32) ? 64'hB7E15163 : 64'hB7E151628AED2A6B;
    q = (w == 16) ? 64'h9E37 : (w == 32) ? 64'h9E3779B9 : 64'h9E3779B97F4A7C15;
    for (int k = 0; k < c; k++) ml[k] = '0;
    for (int k = 0; k < b; k++) ml[k / u] = ml[k / u] | (64'(kb[k]) << (8 * (k % u)));
    ms[0] = p;
    for (int k = 1; k < t; k++) ms[k] = (ms[k-1] + q) & m;
    a = '0; bb = '0; i = 0; j = 0;
    n = 3 * ((t > c) ? t : c);
    for (int k = 0; k < n; k++) begin
      a = rl((ms[i] + a + bb) & m, 64'd3, w);
      ms[i] = a;
      bb = rl((ml[j] + a + bb) & m, a + bb, w);
      ml[j] = bb;
      i = (i + 1) % t;
      j = (j + 1) % c;
    end
  endtask

  task automatic enc_model(input int d, input logic [63:0] a0, input logic [63:0] b0,
                           output logic [63:0] a, output logic [63:0] b);
    logic [63:0] m;
    m = msk(pw[d]);
    a = (a0 + ms[0]) & m;
    b = (b0 + ms[1]) & m;
    for (int k = 1; k <= pr[d]; k++) begin
      a = (rl(a ^ b, b, pw[d]) + ms[2*k]) & m;
      b = (rl(b ^ a, a, pw[d]) + ms[2*k+1]) & m;
    end
  endtask

  task automatic dec_model(input int d, input logic [63:0] a0, input logic [63:0] b0,
                           output logic [63:0] a, output logic [63:0] b);
    logic [63:0] m;
    m = msk(pw[d]);
    a = a0; b = b0;
    for (int k = pr[d]; k >= 1; k--) begin
      b = rr((b - ms[2*k+1]) & m, a, pw[d]) ^ a;
      a = rr((a - ms[2*k]) & m, b, pw[d]) ^ b;
    end
    a = (a - ms[0]) & m;
    b = (b - ms[1]) & m;
  endtask

  // ---------------- bench helpers ----------------
  function automatic logic [63:0] oa(input int d);
    case (d)
      0: return {32'd0, ao0};
      1: return {48'd0, ao1};
      default: return ao2;
    endcase
  endfunction

  function automatic logic [63:0] ob(input int d);
    case (d)
      0: return {32'd0, bo0};
      1: return {48'd0, bo1};
      default: return bo2;
    endcase
  endfunction

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk_zero(input string tag, input int d);
    chk({tag, "_key_ready"}, 64'(kr[d]), 64'd0);
    chk({tag, "_busy"}, 64'(bz[d]), 64'd0);
    chk({tag, "_done"}, 64'(dn[d]), 64'd0);
    chk({tag, "_a_out"}, oa(d), 64'd0);
    chk({tag, "_b_out"}, ob(d), 64'd0);
  endtask

  task automatic load_key(input int d);
    for (int i = 0; i < pb[d]; i++) begin
      key_addr = 5'(i);
      key_byte = kb[i];
      kwr[d] = 1'b1;
      tick;
      kwr[d] = 1'b0;
    end
  endtask

  task automatic do_expand(input int d, input bit hold_start);
    int lat, nd, t, c, u;
    u = pw[d] / 8; c = (pb[d] + u - 1) / u; t = 2 * (pr[d] + 1);
    expand_model(d);
    kexp[d] = 1'b1;
    st[d] = hold_start;
    tick;
    kexp[d] = 1'b0;
    lat = 0;
    nd = (dn[d] === 1'b1) ? 1 : 0;
    while (kr[d] !== 1'b1 && lat < 2000) begin
      tick;
      lat++;
      if (dn[d] === 1'b1) nd++;
    end
    st[d] = 1'b0;
    chk("key_latency", 64'(lat), 64'(t + 3 * ((t > c) ? t : c)));
    if (hold_start) chk("held_start_done_count", 64'(nd), 64'd0);
  endtask

  task automatic do_op(input int d, input logic m, input logic [63:0] a, input logic [63:0] b,
                       output logic [63:0] ya, output logic [63:0] yb);
    int lat;
    a_in = a; b_in = b; mode = m;
    st[d] = 1'b1;
    tick;
    st[d] = 1'b0;
    lat = 0;
    while (dn[d] !== 1'b1 && lat < 1000) begin
      tick;
      lat++;
    end
    chk("done_latency", 64'(lat), 64'(pr[d] + 2));
    ya = oa(d);
    yb = ob(d);
    tick;
    chk("done_single_pulse", 64'(dn[d]), 64'd0);
    chk("busy_after_done", 64'(bz[d]), 64'd0);
  endtask

  task automatic no_done(input string tag, input int d, input int n);
    int nd;
    nd = 0;
    for (int i = 0; i < n; i++) begin
      tick;
      if (dn[d] === 1'b1) nd++;
    end
    chk(tag, 64'(nd), 64'd0);
  endtask

  task automatic round_trip(input int d, input logic [63:0] a, input logic [63:0] b);
    logic [63:0] ya, yb, ea, eb, za, zb;
    enc_model(d, a, b, ea, eb);
    do_op(d, 1'b0, a, b, ya, yb);
    chk("enc_a", ya, ea);
    chk("enc_b", yb, eb);
`ifdef RC5_DECRYPT_EN
    do_op(d, 1'b1, ya, yb, za, zb);
    chk("dec_a", za, a);
    chk("dec_b", zb, b);
`else
    dec_model(d, ya, yb, za, zb);
    chk("model_dec_a", za, a);
    chk("model_dec_b", zb, b);
`endif
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    logic [127:0] kv;
    logic [63:0]  ya, yb, ea, eb;

    rst = 1'b1; kwr = '0; kexp = '0; st = '0;
    key_addr = '0; key_byte = '0; mode = 1'b0; a_in = '0; b_in = '0;
    for (int i = 0; i < 256; i++) kb[i] = '0;
    repeat (3) tick;
    rst = 1'b0;
    tick;
    for (int d = 0; d < 3; d++) chk_zero("reset", d);

    // start before any key expansion is ignored
    a_in = 64'h1234; b_in = 64'h5678;
    st[0] = 1'b1;
    tick;
    st[0] = 1'b0;
    no_done("start_no_key_done", 0, 20);
    chk("start_no_key_a", oa(0), 64'd0);

    // all-zero key, zero plaintext known answer
    do_expand(0, 1'b0);
    chk("key_ready_zero_key", 64'(kr[0]), 64'd1);
    do_op(0, 1'b0, 64'd0, 64'd0, ya, yb);
    chk("kat_a", ya, 64'hEEDBA521);
    chk("kat_b", yb, 64'h6D8F4B15);
    enc_model(0, 64'd0, 64'd0, ea, eb);
    chk("kat_model_a", ya, ea);

    // key_wr after expansion clears key_ready on the next cycle
    kv = 128'hFFFEEEE58684FFF05FFE493853000434;
    for (int i = 0; i < 16; i++) kb[i] = kv[8*i +: 8];
    key_addr = 5'd0; key_byte = kb[0]; kwr[0] = 1'b1;
    tick;
    kwr[0] = 1'b0;
    chk("key_wr_clears_ready", 64'(kr[0]), 64'd0);
    load_key(0);
    a_in = 64'd99; b_in = 64'd98;
    st[0] = 1'b1;
    tick;
    st[0] = 1'b0;
    no_done("start_stale_key_done", 0, 20);
    chk("start_stale_key_a_hold", oa(0), 64'hEEDBA521);

    // key_exp with start held high: expansion wins, no op runs
    do_expand(0, 1'b1);
    chk("held_start_a_hold", oa(0), 64'hEEDBA521);
    chk("held_start_b_hold", ob(0), 64'h6D8F4B15);

    // second known-key case
    do_op(0, 1'b0, 64'd10, 64'd20, ya, yb);
    enc_model(0, 64'd10, 64'd20, ea, eb);
    chk("key2_enc_a", ya, ea);
    chk("key2_enc_b", yb, eb);
`ifdef RC5_DECRYPT_EN
    do_op(0, 1'b1, ya, yb, ya, yb);
    chk("key2_dec_a", ya, 64'h0000000A);
    chk("key2_dec_b", yb, 64'h00000014);
`else
    do_op(0, 1'b1, 64'd10, 64'd20, ya, yb);
    chk("mode_ignored_a", ya, ea);
    chk("mode_ignored_b", yb, eb);
`endif

    for (int n = 0; n < 4; n++) round_trip(0, 64'($urandom), 64'($urandom));

    // reset mid key mixing
    kexp[0] = 1'b1;
    tick;
    kexp[0] = 1'b0;
    repeat (50) tick;
    rst = 1'b1;
    #1;
    chk_zero("rst_kmix", 0);
    tick;
    rst = 1'b0;
    st[0] = 1'b1;
    tick;
    st[0] = 1'b0;
    no_done("rst_kmix_start_done", 0, 20);
    chk("rst_kmix_start_a", oa(0), 64'd0);

    // reset mid round
    for (int i = 0; i < 256; i++) kb[i] = '0;
    do_expand(0, 1'b0);
    do_op(0, 1'b0, 64'd0, 64'd0, ya, yb);
    chk("rekey_kat_a", ya, 64'hEEDBA521);
    a_in = 64'h55; b_in = 64'hAA; mode = 1'b0;
    st[0] = 1'b1;
    tick;
    st[0] = 1'b0;
    repeat (5) tick;
    chk("mid_round_busy", 64'(bz[0]), 64'd1);
    rst = 1'b1;
    #1;
    chk_zero("rst_round", 0);
    tick;
    rst = 1'b0;
    st[0] = 1'b1;
    tick;
    st[0] = 1'b0;
    no_done("rst_round_start_done", 0, 20);
    chk("rst_round_start_b", ob(0), 64'd0);

    // other widths: random key and data
    for (int d = 1; d < 3; d++) begin
      for (int i = 0; i < pb[d]; i++) kb[i] = 8'($urandom);
      load_key(d);
      do_expand(d, 1'b0);
      for (int n = 0; n < 3; n++)
        round_trip(d, {32'($urandom), 32'($urandom)} & msk(pw[d]),
                      {32'($urandom), 32'($urandom)} & msk(pw[d]));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/rc5_core.md
RC5_CORE -- requirements
Module: rc5_core

Interface
REQ-001 SHALL have parameter W, default 32, word width in bits; legal values 16, 32, 64.
REQ-002 SHALL have parameter R, default 12, number of rounds; legal range 1..255.
REQ-003 SHALL have parameter B, default 16, key length in bytes; legal range 1..255.
REQ-004 SHALL derive T=2(R+1), U=W/8 and C=max(1,ceil(B/U)).
REQ-005 clk  in  1  single clock; all state changes on its rising edge.
REQ-006 rst  in  1  reset, asynchronous and active-high.
REQ-007 key_wr  in  1  write strobe for one key byte.
REQ-008 key_addr  in  max(1,clog2(B))  key byte index.
REQ-009 key_byte  in  8  key byte data.
REQ-010 key_exp  in  1  pulse that starts key expansion.
REQ-011 key_ready  out  1  high when the S table is valid for the stored key.
REQ-012 start  in  1  pulse that starts one block operation.
REQ-013 mode  in  1  0 = encrypt, 1 = decrypt; sampled with start.
REQ-014 a_in, b_in  in  W each  input block words.
REQ-015 a_out, b_out  out  W each  result words, registered.
REQ-016 busy  out  1  high during key expansion or a block operation.
REQ-017 done  out  1  one-cycle pulse when a_out/b_out become valid.

Function
REQ-018 Constants SHALL be: W=16 P=B7E1 Q=9E37; W=32 P=B7E15163 Q=9E3779B9; W=64 P=B7E151628AED2A6B Q=9E3779B97F4A7C15.
REQ-019 FSM SHALL have states IDLE, KINIT, KMIX, LOAD, ROUND and OUT.
REQ-020 In IDLE, key_wr SHALL store key_byte at key_addr and clear key_ready; key_wr outside IDLE SHALL be ignored.
REQ-021 key_exp in IDLE SHALL load L little-endian (byte i into L[i/U] bits 8(i%U)+:8, unused bytes 0) and enter KINIT.
REQ-022 KINIT SHALL take T cycles, writing S[0]=P and S[i]=S[i-1]+Q one entry per cycle.
REQ-023 KMIX SHALL take 3*max(T,C) cycles, one RC5 mix step per cycle: A=S[i]=(S[i]+A+Bm)<<<3; Bm=L[j]=(L[j]+A+Bm)<<<(A+Bm); i=(i+1) mod T; j=(j+1) mod C; A, Bm, i and j start at 0.
REQ-024 KMIX end SHALL set key_ready=1 and return to IDLE; the default configuration takes 104 cycles from the key_exp edge.
REQ-025 start in IDLE with key_ready=1 SHALL sample a_in, b_in and mode and enter LOAD; otherwise start SHALL be ignored.
REQ-026 Encrypt: LOAD sets A=a_in+S[0], B=b_in+S[1]; ROUND i=1..R, one per cycle: A=((A^B)<<<B)+S[2i], then B=((B^A)<<<A)+S[2i+1]; OUT copies A, B.
REQ-027 Decrypt: LOAD sets A=a_in, B=b_in; ROUND i=R..1: B=((B-S[2i+1])>>>A)^A, then A=((A-S[2i])>>>B)^B; OUT writes A-S[0], B-S[1].
REQ-028 Rotate amounts SHALL use the low log2(W) bits; all arithmetic SHALL be modulo 2^W.
REQ-029 done SHALL pulse, and a_out/b_out update, exactly R+2 cycles after the start edge; the FSM SHALL be in IDLE on the next cycle.
REQ-030 If key_exp and start are both high in IDLE, key_exp SHALL win and start SHALL be dropped.
REQ-031 start and key_exp SHALL be ignored while busy=1; a_out/b_out SHALL hold between operations.

Reset
REQ-032 rst SHALL force IDLE and clear key_ready, busy, done, a_out, b_out, key bytes, L and S to 0, aborting any operation mid-flight.
REQ-033 After reset, start SHALL be ignored until a new key expansion completes.

Configuration
REQ-034 Macro RC5_DECRYPT_EN defined: both modes SHALL be implemented as above.
REQ-035 Macro RC5_DECRYPT_EN undefined: decrypt datapath SHALL be omitted, mode SHALL be ignored, every operation SHALL encrypt, and latency SHALL be unchanged.

Verification
REQ-036 Default params, all-zero key, key_exp, wait for key_ready, encrypt A=0 B=0 -> key_ready rises 104 cycles after key_exp; a_out=EEDBA521, b_out=6D8F4B15; done pulses 14 cycles after start.
REQ-037 Key FFFEEEE58684FFF05FFE493853000434 (byte i = bits 8i+:8), encrypt A=10 B=20, then decrypt the result -> a_out=0000000A, b_out=00000014.
REQ-038 start held high during expansion, or with key_ready=0 -> no done and no output change; key_wr after expansion -> key_ready=0 on the next cycle.
REQ-039 rst asserted mid-KMIX and again mid-ROUND -> all outputs 0 immediately, key_ready=0, and a subsequent start is ignored.
REQ-040 Simultaneous key_exp and start in IDLE -> expansion runs and no done pulse occurs for that start.
REQ-041 W=16 R=8 B=8 and W=64 R=20 B=24 builds, random key and data, encrypt then decrypt -> original words returned; done latency is R+2 cycles.
